// File: rtl/game_flow_controller_if.sv
// Level-facing and renderer-facing signals of the game sequencer.
// The controller uses the master modport; a level/renderer model uses the slave modport.
interface game_flow_controller_if;
  logic       level_win;
  logic       level_lose;
  logic       level_reset_n;
  logic       play_enable;
  logic [1:0] level_select;
  logic [1:0] lives;
  logic [2:0] game_state;
  logic       banner_active;

  modport master (
    input  level_win, level_lose,
    output level_reset_n, play_enable, level_select, lives, game_state, banner_active
  );

  modport slave (
    output level_win, level_lose,
    input  level_reset_n, play_enable, level_select, lives, game_state, banner_active
  );
endinterface

// File: rtl/game_flow_controller.sv
// Game sequencer: title -> load -> play -> clear/death banners -> game over/victory.
// Owns lives, the active level index and the banner timing; all outputs decode from registers.
module game_flow_controller #(
  parameter int NUM_LEVELS         = 3,
  parameter int START_LIVES        = 3,
  parameter int LEVEL_RESET_CYCLES = 4,
  parameter int BANNER_CYCLES      = 50000000
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start_button,
  game_flow_controller_if.master bus
);

  typedef enum logic [2:0] {
    TITLE       = 3'd0,
    LOAD        = 3'd1,
    PLAY        = 3'd2,
    LEVEL_CLEAR = 3'd3,
    DEATH       = 3'd4,
    GAME_OVER   = 3'd5,
    VICTORY     = 3'd6
  } state_t;

  localparam logic [31:0] LOAD_LAST   = 32'(LEVEL_RESET_CYCLES - 1);
  localparam logic [31:0] BANNER_LAST = 32'(BANNER_CYCLES - 1);
  localparam logic [1:0]  LAST_LEVEL  = 2'(NUM_LEVELS - 1);
  localparam logic [1:0]  FULL_LIVES  = 2'(START_LIVES);

  state_t      state, state_next;
  logic [31:0] counter, counter_next;
  logic [1:0]  level, level_next;
  logic [1:0]  lives_q, lives_next;
  logic        first_play, first_play_next;
  logic        sync0, sync1, prev;
  logic        start_pulse;

  // Two-flop synchroniser plus a delayed copy: one pulse per button press.
  assign start_pulse = sync1 & ~prev;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state      <= TITLE;
      counter    <= '0;
      level      <= '0;
      lives_q    <= FULL_LIVES;
      first_play <= 1'b0;
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      prev       <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      level      <= level_next;
      lives_q    <= lives_next;
      first_play <= first_play_next;
      sync0      <= start_button;
      sync1      <= sync0;
      prev       <= sync1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next      = state;
    counter_next    = counter;
    level_next      = level;
    lives_next      = lives_q;
    first_play_next = 1'b0;

    case (state)
      TITLE: begin
        if (start_pulse) begin
          level_next   = '0;
          lives_next   = FULL_LIVES;
          counter_next = '0;
          state_next   = LOAD;
        end
      end

      LOAD: begin
        if (counter == LOAD_LAST) begin
          counter_next    = '0;
          first_play_next = 1'b1;
          state_next      = PLAY;
        end else begin
          counter_next = counter + 32'd1;
        end
      end

      PLAY: begin
        // The level's flags are still settling from reset on the first cycle.
        if (!first_play) begin
          if (bus.level_win) begin
            counter_next = '0;
            state_next   = LEVEL_CLEAR;
          end else if (bus.level_lose) begin
            counter_next = '0;
            lives_next   = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            state_next   = DEATH;
          end
        end
      end

      LEVEL_CLEAR: begin
        if (counter == BANNER_LAST) begin
          counter_next = '0;
          if (level == LAST_LEVEL) begin
            state_next = VICTORY;
          end else begin
            level_next = level + 2'd1;
            state_next = LOAD;
          end
        end else begin
          counter_next = counter + 32'd1;
        end
      end

      DEATH: begin
        if (counter == BANNER_LAST) begin
          counter_next = '0;
          state_next   = (lives_q == 2'd0) ? GAME_OVER : LOAD;
        end else begin
          counter_next = counter + 32'd1;
        end
      end

      GAME_OVER, VICTORY: begin
        if (start_pulse) state_next = TITLE;
      end

      default: state_next = TITLE;
    endcase
  end

  // The level stays out of reset during banners so its last frame remains visible.
  assign bus.level_reset_n = (state == PLAY) || (state == LEVEL_CLEAR) || (state == DEATH);
  assign bus.play_enable   = (state == PLAY);
  assign bus.banner_active = (state == LEVEL_CLEAR) || (state == DEATH);
  assign bus.level_select  = level;
  assign bus.lives         = lives_q;
  assign bus.game_state    = state;

endmodule
